uart_rx: RTL and testbench

- 8N1 serial receiver for the MIDI input path.
- Takes an asynchronous serial line, synchronises it, finds the start bit and samples each bit at mid-period.
- Presents each received byte with a one-cycle valid pulse.
- Flags framing errors (stop bit = 0) so the router can drop corrupted bytes and resynchronise on line idle.

---
 rtl/uart_rx_if.sv | 26 ++
 rtl/uart_rx.sv | 174 +++++++++++++++++
 tb/tb_uart_rx.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and received-byte signals of the MIDI UART receiver
interface uart_rx_if;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Active;
  logic       o_Rx_Frame_Err;

  // Line driver / byte consumer side
  modport master (
    output i_Rx_Serial,
    input  o_Rx_DV,
    input  o_Rx_Byte,
    input  o_Rx_Active,
    input  o_Rx_Frame_Err
  );

  // Receiver side
  modport slave (
    input  i_Rx_Serial,
    output o_Rx_DV,
    output o_Rx_Byte,
    output o_Rx_Active,
    output o_Rx_Frame_Err
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with mid-bit sampling and framing-error detection
module uart_rx #(
  parameter int CLKS_PER_BIT = 384
) (
  input  logic      i_Clock,
  input  logic      i_Reset,
  uart_rx_if.slave  rx_if
);

  localparam logic [12:0] HALF = 13'((CLKS_PER_BIT - 1) / 2);
  localparam logic [12:0] LAST = 13'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_CLEANUP   = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  logic        r_Sync1;
  logic        r_Rx;
  state_t      r_State;
  logic [12:0] r_Count;
  logic [2:0]  r_Bit_Idx;
  logic [7:0]  r_Shift;
  logic [7:0]  r_Byte;
  logic        r_DV;
  logic        r_Err;
  logic        r_Active;

  state_t      w_State_Next;
  logic [12:0] w_Count_Next;
  logic [2:0]  w_Bit_Idx_Next;
  logic [7:0]  w_Shift_Next;
  logic [7:0]  w_Byte_Next;
  logic        w_DV_Next;
  logic        w_Err_Next;
  logic        w_Active_Next;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Sync1 <= 1'b1;
      r_Rx    <= 1'b1;
    end else begin
      r_Sync1 <= rx_if.i_Rx_Serial;
      r_Rx    <= r_Sync1;
    end
  end

  // State and datapath registers
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State   <= S_IDLE;
      r_Count   <= 13'd0;
      r_Bit_Idx <= 3'd0;
      r_Shift   <= 8'h00;
      r_Byte    <= 8'h00;
      r_DV      <= 1'b0;
      r_Err     <= 1'b0;
      r_Active  <= 1'b0;
    end else begin
      r_State   <= w_State_Next;
      r_Count   <= w_Count_Next;
      r_Bit_Idx <= w_Bit_Idx_Next;
      r_Shift   <= w_Shift_Next;
      r_Byte    <= w_Byte_Next;
      r_DV      <= w_DV_Next;
      r_Err     <= w_Err_Next;
      r_Active  <= w_Active_Next;
    end
  end

  // Next-state and output decode; pulses default low so they last one cycle
  always_comb begin
    w_State_Next   = r_State;
    w_Count_Next   = r_Count;
    w_Bit_Idx_Next = r_Bit_Idx;
    w_Shift_Next   = r_Shift;
    w_Byte_Next    = r_Byte;
    w_DV_Next      = 1'b0;
    w_Err_Next     = 1'b0;
    w_Active_Next  = r_Active;

    case (r_State)
      S_IDLE: begin
        w_Count_Next   = 13'd0;
        w_Bit_Idx_Next = 3'd0;
        w_Active_Next  = 1'b0;
        if (!r_Rx) begin
          w_State_Next  = S_START;
          w_Active_Next = 1'b1;
        end
      end

      // Re-check the line at the middle of the start bit to reject glitches
      S_START: begin
        w_Active_Next = 1'b1;
        if (r_Count == HALF) begin
          w_Count_Next = 13'd0;
          if (!r_Rx) begin
            w_State_Next = S_DATA;
          end else begin
            w_State_Next  = S_IDLE;
            w_Active_Next = 1'b0;
          end
        end else begin
          w_Count_Next = r_Count + 13'd1;
        end
      end

      // Counter is now aligned to mid-bit; one full period lands on the next bit centre
      S_DATA: begin
        if (r_Count == LAST) begin
          w_Count_Next            = 13'd0;
          w_Shift_Next[r_Bit_Idx] = r_Rx;
          if (r_Bit_Idx != 3'd7) begin
            w_Bit_Idx_Next = r_Bit_Idx + 3'd1;
          end else begin
            w_Bit_Idx_Next = 3'd0;
            w_State_Next   = S_STOP;
          end
        end else begin
          w_Count_Next = r_Count + 13'd1;
        end
      end

      // A low stop bit discards the byte and waits for the line to recover
      S_STOP: begin
        if (r_Count == LAST) begin
          w_Count_Next = 13'd0;
          if (r_Rx) begin
            w_Byte_Next  = r_Shift;
            w_DV_Next    = 1'b1;
            w_State_Next = S_CLEANUP;
          end else begin
            w_Err_Next   = 1'b1;
            w_State_Next = S_WAIT_HIGH;
          end
        end else begin
          w_Count_Next = r_Count + 13'd1;
        end
      end

      S_CLEANUP: begin
        w_Active_Next = 1'b0;
        w_State_Next  = S_IDLE;
      end

      // Break or stuck-low line: hold off until it returns high
      S_WAIT_HIGH: begin
        w_Active_Next = 1'b0;
        if (r_Rx) begin
          w_State_Next = S_IDLE;
        end
      end

      default: begin
        w_State_Next   = S_IDLE;
        w_Count_Next   = 13'd0;
        w_Bit_Idx_Next = 3'd0;
        w_Active_Next  = 1'b0;
      end
    endcase
  end

  assign rx_if.o_Rx_DV        = r_DV;
  assign rx_if.o_Rx_Byte      = r_Byte;
  assign rx_if.o_Rx_Active    = r_Active;
  assign rx_if.o_Rx_Frame_Err = r_Err;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized and directed self-checking bench for uart_rx
module tb_uart_rx;

  localparam int CPB      = 384;
  localparam int HALF_B   = (CPB - 1) / 2;
  localparam int STOP_LAT = 2 + HALF_B + 9 * CPB;

  typedef struct {
    int         t;
    bit         is_err;
    logic [7:0] b;
  } exp_t;

  logic i_Clock = 1'b0;
  logic i_Reset = 1'b1;
  uart_rx_if u_if ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .rx_if   (u_if)
  );

  always #5 i_Clock = ~i_Clock;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       q[$];
  exp_t       ce;
  int         dv_times[$];
  int         dv_seen = 0;
  int         err_seen = 0;
  logic [7:0] exp_byte = 8'h00;
  bit         chk_en = 1'b0;
  bit         prev_pulse = 1'b0;

  always @(posedge i_Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the expected-event queue
  always @(negedge i_Clock) begin
    if (!chk_en) begin
      prev_pulse = 1'b0;
    end else begin
      chk("dv_err_exclusive", {31'b0, u_if.o_Rx_DV & u_if.o_Rx_Frame_Err}, 32'd0);
      if (u_if.o_Rx_DV || u_if.o_Rx_Frame_Err) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got dv=%0b err=%0b at cycle %0d, expected none",
                   u_if.o_Rx_DV, u_if.o_Rx_Frame_Err, cyc);
        end else begin
          ce = q.pop_front();
          chk_rng("pulse_time", cyc, ce.t - 1, ce.t + 1);
          chk("pulse_kind_err", {31'b0, u_if.o_Rx_Frame_Err}, {31'b0, ce.is_err});
          chk("active_on_pulse", {31'b0, u_if.o_Rx_Active}, 32'd1);
          if (u_if.o_Rx_DV) begin
            chk("rx_byte", {24'b0, u_if.o_Rx_Byte}, {24'b0, ce.b});
            exp_byte = ce.b;
            dv_seen++;
            dv_times.push_back(cyc);
          end else begin
            chk("byte_held_on_err", {24'b0, u_if.o_Rx_Byte}, {24'b0, exp_byte});
            err_seen++;
          end
        end
      end else begin
        chk("rx_byte_hold", {24'b0, u_if.o_Rx_Byte}, {24'b0, exp_byte});
      end
      if (prev_pulse) chk("active_after_pulse", {31'b0, u_if.o_Rx_Active}, 32'd0);
      prev_pulse = u_if.o_Rx_DV | u_if.o_Rx_Frame_Err;
      if (q.size() != 0 && cyc > q[0].t + 1) begin
        checks++;
        errors++;
        $display("FAIL missing_pulse: got nothing by cycle %0d, expected %s near %0d",
                 cyc, q[0].is_err ? "frame_err" : "dv", q[0].t);
        void'(q.pop_front());
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge i_Clock);
    #1;
  endtask

  task automatic idle(input int n);
    u_if.i_Rx_Serial = 1'b1;
    hold(n);
  endtask

  // Transmit one frame; predicts the stop-bit decision from the start-bit edge
  task automatic send_frame(input logic [7:0] b, input int per, input bit stop_ok, output int t0);
    exp_t e;
    u_if.i_Rx_Serial = 1'b0;
    t0 = cyc;
    e.t = t0 + 1 + STOP_LAT;
    e.is_err = !stop_ok;
    e.b = b;
    q.push_back(e);
    hold(per);
    for (int i = 0; i < 8; i++) begin
      u_if.i_Rx_Serial = b[i];
      hold(per);
    end
    u_if.i_Rx_Serial = stop_ok;
    hold(per);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no finish by %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n0;
    int d0;
    int e0;
    logic [7:0] rb;
    int per;
    bit ok;

    u_if.i_Rx_Serial = 1'b1;
    hold(3);
    chk("reset_dv", {31'b0, u_if.o_Rx_DV}, 32'd0);
    chk("reset_byte", {24'b0, u_if.o_Rx_Byte}, 32'h00);
    chk("reset_active", {31'b0, u_if.o_Rx_Active}, 32'd0);
    chk("reset_err", {31'b0, u_if.o_Rx_Frame_Err}, 32'd0);
    i_Reset = 1'b0;
    idle(10);
    chk_en = 1'b1;

    // Single ideal frame
    send_frame(8'h90, CPB, 1'b1, t0);
    idle(50);
    chk("t1_dv_count", dv_seen, 1);
    chk_rng("t1_latency", dv_times[0] - t0, 3649, 3651);
    chk("t1_byte", {24'b0, u_if.o_Rx_Byte}, 32'h90);
    chk("t1_err_count", err_seen, 0);

    // Back-to-back frames with no gap
    n0 = dv_times.size();
    send_frame(8'h90, CPB, 1'b1, t0);
    send_frame(8'h3C, CPB, 1'b1, t0);
    send_frame(8'h7F, CPB, 1'b1, t0);
    idle(50);
    chk("t2_dv_count", dv_times.size() - n0, 3);
    chk("t2_gap1", dv_times[n0 + 1] - dv_times[n0], 3840);
    chk("t2_gap2", dv_times[n0 + 2] - dv_times[n0 + 1], 3840);
    chk("t2_byte", {24'b0, u_if.o_Rx_Byte}, 32'h7F);

    // Short glitch then a real frame
    d0 = dv_seen;
    e0 = err_seen;
    u_if.i_Rx_Serial = 1'b0;
    hold(100);
    idle(400);
    chk("t3_glitch_dv", dv_seen - d0, 0);
    chk("t3_glitch_err", err_seen - e0, 0);
    send_frame(8'h55, CPB, 1'b1, t0);
    idle(50);
    chk("t3_byte", {24'b0, u_if.o_Rx_Byte}, 32'h55);

    // Framing error followed by a long break
    d0 = dv_seen;
    e0 = err_seen;
    send_frame(8'hA5, CPB, 1'b0, t0);
    hold(5000);
    chk("t4_err_count", err_seen - e0, 1);
    chk("t4_dv_count", dv_seen - d0, 0);
    chk("t4_byte_kept", {24'b0, u_if.o_Rx_Byte}, 32'h55);
    idle(50);
    send_frame(8'h12, CPB, 1'b1, t0);
    idle(50);
    chk("t4_dv_after", dv_seen - d0, 1);
    chk("t4_byte_new", {24'b0, u_if.o_Rx_Byte}, 32'h12);

    // Baud skew both ways
    send_frame(8'hC3, 373, 1'b1, t0);
    idle(50);
    chk("t5_fast_byte", {24'b0, u_if.o_Rx_Byte}, 32'hC3);
    send_frame(8'h00, CPB, 1'b1, t0);
    idle(20);
    send_frame(8'hC3, 395, 1'b1, t0);
    idle(50);
    chk("t5_slow_byte", {24'b0, u_if.o_Rx_Byte}, 32'hC3);

    // Asynchronous reset in the middle of the data bits of 0xFF
    u_if.i_Rx_Serial = 1'b0;
    hold(CPB);
    u_if.i_Rx_Serial = 1'b1;
    hold(2 * CPB);
    chk("t6_active_mid", {31'b0, u_if.o_Rx_Active}, 32'd1);
    chk_en = 1'b0;
    #3;
    i_Reset = 1'b1;
    #1;
    chk("t6_rst_dv", {31'b0, u_if.o_Rx_DV}, 32'd0);
    chk("t6_rst_byte", {24'b0, u_if.o_Rx_Byte}, 32'h00);
    chk("t6_rst_active", {31'b0, u_if.o_Rx_Active}, 32'd0);
    chk("t6_rst_err", {31'b0, u_if.o_Rx_Frame_Err}, 32'd0);
    q.delete();
    exp_byte = 8'h00;
    hold(5);
    i_Reset = 1'b0;
    idle(10 * CPB);
    chk_en = 1'b1;
    send_frame(8'h01, CPB, 1'b1, t0);
    idle(50);
    chk("t6_byte", {24'b0, u_if.o_Rx_Byte}, 32'h01);

    // Randomized frames: random byte, skewed baud, occasional bad stop bit
    for (int k = 0; k < 5; k++) begin
      rb = 8'($urandom);
      per = 373 + $urandom_range(0, 22);
      ok = ($urandom_range(0, 3) != 0);
      send_frame(rb, per, ok, t0);
      if (!ok) hold($urandom_range(10, 500));
      idle($urandom_range(2, 200));
    end

    idle(300);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
